// File: rtl/feature_map_streamer.sv
`default_nettype none
// ============================================================================
// Module   : feature_map_streamer
// Brief    : Per-channel row-major feature-map reader feeding a conv core input,
//            with an output register plus one skid entry per lane.
// Revision : 1.0
// ============================================================================
module feature_map_streamer #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    N_ROWS     = 28,
    parameter int                    N_COLS     = 28,
    parameter int                    N_CHANNELS = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                             clock_i,
    input  logic                             reset_ni,
    input  logic                             start_i,
    input  logic [N_CHANNELS-1:0]            hold_data_i,
    output logic [N_CHANNELS-1:0]            mem_rd_en_o,
    output logic [N_CHANNELS*ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] mem_data_i,
    output logic [N_CHANNELS-1:0]            data_valid_o,
    output logic [N_CHANNELS*DATA_WIDTH-1:0] data_o,
    output logic                             busy_o,
    output logic                             done_o
);

    localparam int TOTAL = N_ROWS * N_COLS;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } lane_state_e;

    logic                  start_go;
    logic [N_CHANNELS-1:0] lane_busy;
    logic [N_CHANNELS-1:0] lane_busy_d;
    logic                  done_q;
    logic                  done_d;

    assign busy_o   = |lane_busy;
    assign start_go = start_i && !busy_o;

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_lane
        lane_state_e           state_q, state_d;
        logic [IDX_W-1:0]      idx_q, idx_d;
        logic [ADDR_WIDTH-1:0] addr_q, addr_d;
        logic                  inflight_q, inflight_d;
        logic                  out_vld_q, out_vld_d;
        logic                  skid_vld_q, skid_vld_d;
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
        logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
        logic                  xfer;
        logic                  issue;
        logic [1:0]            occ;
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0] rd_data;

        assign rd_data = mem_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        assign rd_addr = BASE_ADDR + ADDR_WIDTH'(idx_q);
        assign occ     = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(inflight_q);

        // An unknown hold fails the if-condition, so it behaves as hold=1.
        always_comb begin
            xfer = 1'b0;
            if (out_vld_q && !hold_data_i[c]) begin
                xfer = 1'b1;
            end
        end

        // A word leaving this cycle frees its slot for a new request.
        assign issue = (state_q == ST_STREAM) && (occ < (xfer ? 2'd3 : 2'd2));

        always_comb begin
            state_d     = state_q;
            idx_d       = idx_q;
            addr_d      = addr_q;
            inflight_d  = issue;
            out_vld_d   = out_vld_q;
            out_data_d  = out_data_q;
            skid_vld_d  = skid_vld_q;
            skid_data_d = skid_data_q;

            if (xfer) begin
                if (skid_vld_q) begin
                    out_data_d = skid_data_q;
                    skid_vld_d = 1'b0;
                end else begin
                    out_vld_d = 1'b0;
                end
            end
            if (inflight_q) begin
                if (!out_vld_d) begin
                    out_vld_d  = 1'b1;
                    out_data_d = rd_data;
                end else begin
                    skid_vld_d  = 1'b1;
                    skid_data_d = rd_data;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_go) begin
                        state_d = ST_STREAM;
                        idx_d   = '0;
                    end
                end
                ST_STREAM: begin
                    if (issue) begin
                        addr_d = rd_addr;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DRAIN;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer && !skid_vld_q && !inflight_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clock_i or negedge reset_ni) begin
            if (!reset_ni) begin
                state_q     <= ST_IDLE;
                idx_q       <= '0;
                addr_q      <= '0;
                inflight_q  <= 1'b0;
                out_vld_q   <= 1'b0;
                out_data_q  <= '0;
                skid_vld_q  <= 1'b0;
                skid_data_q <= '0;
            end else begin
                state_q     <= state_d;
                idx_q       <= idx_d;
                addr_q      <= addr_d;
                inflight_q  <= inflight_d;
                out_vld_q   <= out_vld_d;
                out_data_q  <= out_data_d;
                skid_vld_q  <= skid_vld_d;
                skid_data_q <= skid_data_d;
            end
        end

        assign mem_rd_en_o[c]                         = issue;
        assign mem_addr_o[c*ADDR_WIDTH +: ADDR_WIDTH] = issue ? rd_addr : addr_q;
        assign data_valid_o[c]                        = out_vld_q;
        assign data_o[c*DATA_WIDTH +: DATA_WIDTH]     = out_data_q;
        assign lane_busy[c]                           = (state_q != ST_IDLE);
        assign lane_busy_d[c]                         = (state_d != ST_IDLE);
    end

    // Single pulse however many lanes retire on the same edge.
    assign done_d = busy_o && !(|lane_busy_d);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_feature_map_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_feature_map_streamer
// Brief    : Scoreboard bench for feature_map_streamer with a memory model.
// Revision : 1.0
// ============================================================================
module tb_feature_map_streamer;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int NR    = 4;
    localparam int NC    = 4;
    localparam int NCH   = 2;
    localparam int TOTAL = NR * NC;
    localparam logic [AW-1:0] BASE = 16'hFFFE;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NCH-1:0]    hold = '0;
    logic [NCH-1:0]    hold_manual = '0;
    logic [NCH-1:0]    rd_en;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] mdata = '0;
    logic [NCH-1:0]    dvalid;
    logic [NCH*DW-1:0] dout;
    logic              busy;
    logic              done;

    int vectors = 0;
    int errors = 0;
    int done_cnt = 0;
    int hold_mode = 0;
    int issued [NCH];
    int xfers [NCH];
    logic held_prev [NCH];
    logic [DW-1:0] held_data [NCH];
    logic [DW-1:0] exp_q [NCH][$];

    feature_map_streamer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_ROWS     (NR),
        .N_COLS     (NC),
        .N_CHANNELS (NCH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clock_i      (clk),
        .reset_ni     (rst_n),
        .start_i      (start),
        .hold_data_i  (hold),
        .mem_rd_en_o  (rd_en),
        .mem_addr_o   (addr),
        .mem_data_i   (mdata),
        .data_valid_o (dvalid),
        .data_o       (dout),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memfn(input int c, input logic [AW-1:0] a);
        return (DW'(c) << 24) | DW'(a) | 32'h0050_0000;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (rd_en[c]) mdata[c*DW +: DW] <= memfn(c, addr[c*AW +: AW]);
        end
    end

    always @(posedge clk) begin
        #1;
        case (hold_mode)
            0: hold = '0;
            1: hold = {1'b0, 1'($urandom_range(0, 99) < 60)};
            2: hold = NCH'($urandom);
            default: hold = hold_manual;
        endcase
    end

    // Monitor / scoreboard
    logic [DW-1:0] got;
    logic [DW-1:0] exp_w;
    logic [AW-1:0] exp_a;
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                exp_q[c].delete();
                issued[c] = 0;
                xfers[c] = 0;
                held_prev[c] = 1'b0;
            end
        end else begin
            if (done) done_cnt++;
            for (int c = 0; c < NCH; c++) begin
                got = dout[c*DW +: DW];
                if (rd_en[c]) begin
                    exp_a = AW'(int'(BASE) + (issued[c] % TOTAL));
                    vectors++;
                    if (addr[c*AW +: AW] !== exp_a) begin
                        errors++;
                        $display("FAIL rd_addr lane%0d: got %h expected %h", c, addr[c*AW +: AW], exp_a);
                    end
                    issued[c]++;
                end
                if (held_prev[c]) begin
                    vectors++;
                    if (dvalid[c] !== 1'b1 || got !== held_data[c]) begin
                        errors++;
                        $display("FAIL hold_stable lane%0d: got valid=%b data=%h expected valid=1 data=%h",
                                 c, dvalid[c], got, held_data[c]);
                    end
                end
                held_prev[c] = dvalid[c] & hold[c];
                held_data[c] = got;
                if (dvalid[c] && !hold[c]) begin
                    xfers[c]++;
                    vectors++;
                    if (exp_q[c].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word lane%0d: got %h expected no word", c, got);
                    end else begin
                        exp_w = exp_q[c].pop_front();
                        if (got !== exp_w) begin
                            errors++;
                            $display("FAIL data lane%0d: got %h expected %h", c, got, exp_w);
                        end
                    end
                end
                vectors++;
                if (issued[c] - xfers[c] > 2) begin
                    errors++;
                    $display("FAIL outstanding lane%0d: got %0d expected <= 2", c, issued[c] - xfers[c]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream();
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < TOTAL; i++)
                exp_q[c].push_back(memfn(c, AW'(int'(BASE) + i)));
    endtask

    task automatic launch();
        push_stream();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, int'(seen), 1);
        check({name, "_busy_low"}, int'(busy), 0);
        for (int c = 0; c < NCH; c++)
            check({name, "_words_left"}, exp_q[c].size(), 0);
        tick();
    endtask

    initial begin
        int first_v, v0, v1, done_at, d0, reads, held_v;
        bit seen;

        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_valid", int'(dvalid), 0);
        check("reset_data_zero", int'(dout != '0), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst_n = 1'b1;
        tick();

        // Free run: latency, throughput and single done pulse
        d0 = done_cnt; first_v = -1; v0 = 0; v1 = 0; done_at = -1;
        launch();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (dvalid[0]) begin
                if (first_v < 0) first_v = k;
                v0++;
            end
            if (dvalid[1]) v1++;
            if (done && done_at < 0) done_at = k;
        end
        check("free_first_valid", first_v, 2);
        check("free_valid_cycles_l0", v0, 16);
        check("free_valid_cycles_l1", v1, 16);
        check("free_done_cycle", done_at, 18);
        check("free_done_pulses", done_cnt - d0, 1);
        check("free_busy_after", int'(busy), 0);
        tick();

        // Random back-pressure on lane 0 only
        hold_mode = 1;
        launch();
        for (int k = 0; k < 19; k++) @(negedge clk);
        check("bp_lane1_finished", exp_q[1].size(), 0);
        wait_done("bp", 300);
        hold_mode = 0;
        tick();

        // Long stall on lane 0 from the first valid word
        hold_manual = 2'b01;
        hold_mode = 3;
        tick();
        launch();
        reads = 0; held_v = 0; v1 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rd_en[0]) reads++;
            if (dvalid[0]) held_v++;
            if (dvalid[1]) v1++;
        end
        hold_manual = 2'b00;
        check("stall_reads_l0", reads, 2);
        check("stall_valid_l0", held_v, 10);
        check("stall_valid_l1", v1, 10);
        wait_done("stall", 200);
        hold_mode = 0;

        // Start mid-stream is ignored; start in the done cycle is taken
        d0 = done_cnt;
        launch();
        repeat (6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("ign_done_seen", int'(seen), 1);
        launch();
        check("ign_done_pulses", done_cnt - d0, 1);
        check("ign_restart_busy", int'(busy), 1);
        wait_done("restart", 200);
        check("restart_done_pulses", done_cnt - d0, 2);

        // Random hold on both lanes
        for (int r = 0; r < 3; r++) begin
            hold_mode = 2;
            launch();
            wait_done("rand", 400);
            hold_mode = 0;
        end

        // Asynchronous reset around word 7
        launch();
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (xfers[0] >= 7) seen = 1'b1;
        end
        check("rst_reach_word7", int'(seen), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_rd_en", int'(rd_en), 0);
        check("arst_valid", int'(dvalid), 0);
        check("arst_data_zero", int'(dout != '0), 0);
        check("arst_addr_zero", int'(addr != '0), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        launch();
        wait_done("post_reset", 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/feature_map_streamer.md
Name: feature_map_streamer

Overview:
- Source-side driver for the per-channel input stream of a convolution core.
- On start, each channel lane reads one N_ROWS x N_COLS feature map from its own synchronous memory port, in row-major order.
- Each lane presents words on the data_valid_o / data_o / hold_data_i handshake, honouring back-pressure independently per channel.
- Sits between the feature-map RAMs and the conv core input.

Parameters:
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 32, data word width
N_ROWS, 28, feature map rows
N_COLS, 28, feature map columns
N_CHANNELS, 32, number of independent channel lanes
BASE_ADDR, 0, address of element (0,0) in every channel memory

Ports:
clock_i  in  1  clock, all logic on rising edge
reset_ni  in  1  asynchronous active-low reset
start_i  in  1  start pulse; sampled only when busy_o=0
hold_data_i  in  1 x N_CHANNELS  consumer back-pressure per channel
mem_rd_en_o  out  1 x N_CHANNELS  memory read enable per channel
mem_addr_o  out  ADDR_WIDTH x N_CHANNELS  read address per channel
mem_data_i  in  DATA_WIDTH x N_CHANNELS  read data, valid 1 cycle after mem_rd_en_o
data_valid_o  out  1 x N_CHANNELS  output word valid per channel
data_o  out  DATA_WIDTH x N_CHANNELS  output word per channel
busy_o  out  1  any lane active
done_o  out  1  one-cycle pulse when the last lane finishes

Behaviour:
- Reset (reset_ni=0, asynchronous):
  - All lanes go to IDLE; address counters = 0.
  - mem_rd_en_o=0, data_valid_o=0, busy_o=0, done_o=0.
  - Skid entries are emptied and any in-flight read is discarded.
  - data_o is 0.
- Transfer rule: a word transfers on a rising edge where data_valid_o[c]=1 and hold_data_i[c]=0.
  - While hold is high, data_valid_o and data_o stay stable.
  - An X on hold_data_i[c] is treated as hold=1.
- Lane FSM, one per channel: IDLE -> STREAM -> DRAIN -> IDLE.
  - IDLE -> STREAM: when start_i=1 and busy_o=0. All lanes start on the same edge.
  - STREAM:
    - Issue a read (mem_rd_en_o[c]=1, mem_addr_o[c]=BASE_ADDR+idx) only when (words held + reads in flight) < 2.
    - idx runs 0..N_ROWS*N_COLS-1, row-major; it increments by 1 per issued read.
    - Address arithmetic wraps modulo 2^ADDR_WIDTH.
  - STREAM -> DRAIN: after the read for idx=N_ROWS*N_COLS-1 is issued.
  - DRAIN -> IDLE: when the final word transfers.
- Per-lane storage is an output register plus one skid register.
  - Returning read data goes to the output register if it is empty or transferring this cycle; otherwise it goes to the skid register.
  - Order is strictly preserved.
  - Capacity 2 guarantees no data loss under any hold pattern.
- Throughput: with hold continuously 0, one word per cycle per lane after a 2-cycle start latency.
  - start_i sampled at edge T -> first read issued in cycle T+1 -> data_valid_o=1 in cycle T+2.
- Lane independence: lanes stall individually. A held lane does not affect the others.
- mem_rd_en_o=0 whenever no read is issued; mem_addr_o holds its last value.
- busy_o = OR of all lanes not in IDLE.
- done_o:
  - Pulses 1 cycle, in the cycle after the edge where the last remaining lane returns to IDLE.
  - If multiple lanes finish on the same edge, only one pulse is produced.
- start_i while busy_o=1 is ignored, with no effect on counters.
- A start_i on the same cycle as the done_o pulse is accepted, because busy_o is already 0.
- Reset mid-stream aborts immediately. A new start after reset restarts at idx 0.
- Degenerate case N_ROWS*N_COLS=1: STREAM issues one read and moves straight to DRAIN.

Test Plan:
- Free run: N_ROWS=N_COLS=4, N_CHANNELS=2, mem[a]=a+100*c, hold=0, pulse start.
  - Required: each lane emits 100*c+0..15 in order on 16 consecutive cycles starting 2 cycles after start.
  - done_o pulses once; busy_o falls after.
- Back-pressure: hold_data_i[0] toggles 1,1,0,1,0,... and hold_data_i[1]=0.
  - Required: lane 0 emits the full sequence with no loss or duplicate, data stable while held, and never more than 2 reads outstanding+stored.
  - Lane 1 finishes in 16 cycles.
- Long stall: hold_data_i[0]=1 for 10 cycles right after the first valid word.
  - Required: exactly 2 reads issued during the stall (idx 0 and 1); streaming resumes with 1 then 2, etc.
- Ignored start: pulse start_i again mid-stream.
  - Required: sequence unaffected, done_o single pulse.
  - A start pulsed in the done_o cycle begins a new stream from idx 0.
- Async reset: assert reset_ni=0 between clock edges at word 7.
  - Required: outputs 0 immediately without waiting for a clock edge.
  - After release and start, the stream restarts at word 0, and read data from the aborted read never appears on data_o.
- Address base: BASE_ADDR=16'hFFFE with 4 elements.
  - Required: mem_addr_o sequence FFFE, FFFF, 0000, 0001.
